// File: rtl/press_event_pkg.sv
// Shared state encoding and default gesture timing for the button press decoder
// and its consumers.
package press_event_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESSED  = 3'd1,
    HELD     = 3'd2,
    GAP      = 3'd3,
    SECOND   = 3'd4,
    WAIT_REL = 3'd5
  } press_state_t;

  localparam int unsigned DEF_LONG_CYCLES   = 50_000_000;
  localparam int unsigned DEF_GAP_CYCLES    = 25_000_000;
  localparam int unsigned DEF_REPEAT_CYCLES = 10_000_000;
  localparam int unsigned DEF_CNT_W         = 26;

endpackage

// File: rtl/press_event_decoder.sv
// Turns debounced press/release pulses into short/long/double press and
// auto-repeat gesture pulses; all outputs come straight from flops.
module press_event_decoder
  import press_event_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int unsigned GAP_CYCLES    = DEF_GAP_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic pb_down,
  input  logic pb_up,
  output logic short_press,
  output logic long_press,
  output logic repeat_tick,
  output logic double_press,
  output logic busy
);

  localparam logic [CNT_W-1:0] LONG_TERM   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_TERM    = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_CYCLES - 1);

  press_state_t     state;
  logic [CNT_W-1:0] cnt;
  logic             down;
  logic             up;

  // Coincident press and release cancel each other out.
  assign down = pb_down & ~pb_up;
  assign up   = pb_up & ~pb_down;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      repeat_tick  <= 1'b0;
      double_press <= 1'b0;
      busy         <= 1'b0;
    end else begin
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      repeat_tick  <= 1'b0;
      double_press <= 1'b0;
      cnt          <= cnt + CNT_W'(1);
      case (state)
        IDLE: begin
          cnt <= '0;
          if (down) begin
            state <= PRESSED;
            busy  <= 1'b1;
          end
        end
        PRESSED: begin
          if (up) begin
            state <= GAP;
            cnt   <= '0;
          end else if (cnt == LONG_TERM) begin
            long_press <= 1'b1;
            state      <= HELD;
            cnt        <= '0;
          end
        end
        HELD: begin
          // Release beats a coincident repeat tick.
          if (up) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (cnt == REPEAT_TERM) begin
            repeat_tick <= 1'b1;
            cnt         <= '0;
          end
        end
        GAP: begin
          if (down) begin
            state <= SECOND;
            cnt   <= '0;
          end else if (cnt == GAP_TERM) begin
            short_press <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
            cnt         <= '0;
          end
        end
        SECOND: begin
          if (up) begin
            double_press <= 1'b1;
            state        <= IDLE;
            busy         <= 1'b0;
            cnt          <= '0;
          end else if (cnt == LONG_TERM) begin
            double_press <= 1'b1;
            state        <= WAIT_REL;
            cnt          <= '0;
          end
        end
        WAIT_REL: begin
          // Untimed wait: hold the counter so an endless hold cannot wrap it.
          cnt <= '0;
          if (up) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_press_event_decoder.sv
// Directed gestures plus random button activity, checked cycle by cycle against
// a timestamp-based gesture model.
module tb_press_event_decoder;
  import press_event_pkg::*;

  localparam int LONG = 8;
  localparam int GAPC = 4;
  localparam int REP  = 3;

  logic clk = 1'b0;
  logic reset, pb_down, pb_up;
  logic short_press, long_press, repeat_tick, double_press, busy;

  int checks = 0;
  int errors = 0;
  int t = 0;

  // Reference model: absolute-time bookkeeping of the gesture in progress.
  bit in_gesture = 0;
  bit btn_down   = 0;
  bit long_done  = 0;
  int presses    = 0;
  int mark       = 0;
  int t_long     = 0;
  bit e_s, e_l, e_r, e_d, e_b;

  press_event_decoder #(
    .LONG_CYCLES  (LONG),
    .GAP_CYCLES   (GAPC),
    .REPEAT_CYCLES(REP),
    .CNT_W        (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pb_down     (pb_down),
    .pb_up       (pb_up),
    .short_press (short_press),
    .long_press  (long_press),
    .repeat_tick (repeat_tick),
    .double_press(double_press),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Expected outputs for the cycle after inputs (d,u,r) are sampled in cycle t.
  task automatic model(input bit d, input bit u, input bit r);
    bit dd, uu;
    int el;
    dd = d & ~u;
    uu = u & ~d;
    el = t - mark;
    e_s = 0; e_l = 0; e_r = 0; e_d = 0;
    if (r) begin
      in_gesture = 0;
    end else if (!in_gesture) begin
      if (dd) begin
        in_gesture = 1; presses = 1; btn_down = 1; long_done = 0; mark = t;
      end
    end else if (!btn_down) begin
      if (dd) begin
        presses = 2; btn_down = 1; long_done = 0; mark = t;
      end else if (el == GAPC) begin
        e_s = 1; in_gesture = 0;
      end
    end else if (uu) begin
      if (presses == 1 && !long_done) begin
        btn_down = 0; mark = t;
      end else begin
        if (presses == 2 && !long_done) e_d = 1;
        in_gesture = 0;
      end
    end else if (!long_done && el == LONG) begin
      long_done = 1; t_long = t;
      if (presses == 1) e_l = 1; else e_d = 1;
    end else if (long_done && presses == 1 && ((t - t_long) % REP) == 0) begin
      e_r = 1;
    end
    e_b = in_gesture;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed %b expected %b", tag, t, obs, exp);
    end
  endtask

  task automatic step(input bit d, input bit u, input bit r);
    pb_down = d; pb_up = u; reset = r;
    model(d, u, r);
    @(posedge clk);
    #1;
    t++;
    chk("short_press", short_press, e_s);
    chk("long_press", long_press, e_l);
    chk("repeat_tick", repeat_tick, e_r);
    chk("double_press", double_press, e_d);
    chk("busy", busy, e_b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  initial begin
    bit d, u, r, btn;
    int hold, k;
    pb_down = 0; pb_up = 0; reset = 1;
    #1;
    step(0, 0, 1);
    step(0, 0, 1);
    idle(3);

    $display("gesture: short press");
    step(1, 0, 0); idle(2); step(0, 1, 0); idle(8);
    $display("gesture: long press with repeats");
    step(1, 0, 0); idle(19); step(0, 1, 0); idle(8);
    $display("gesture: release on a repeat boundary");
    step(1, 0, 0); idle(10); step(0, 1, 0); idle(6);
    $display("gesture: double press");
    step(1, 0, 0); idle(1); step(0, 1, 0); idle(1); step(1, 0, 0); idle(1); step(0, 1, 0); idle(6);
    $display("gesture: second press on gap terminal cycle");
    step(1, 0, 0); idle(1); step(0, 1, 0); idle(3); step(1, 0, 0); idle(1); step(0, 1, 0); idle(6);
    $display("gesture: second press held long");
    step(1, 0, 0); idle(1); step(0, 1, 0); idle(3); step(1, 0, 0); idle(19); step(0, 1, 0); idle(6);
    $display("gesture: ignored coincident and stray edges");
    step(1, 1, 0); step(0, 1, 0); idle(4);
    $display("gesture: reset during held");
    step(1, 0, 0); idle(10); step(0, 0, 1); idle(2); step(0, 1, 0); idle(8);

    $display("gesture: random activity");
    btn = 0; hold = 0;
    for (int i = 0; i < 4000; i++) begin
      d = 0; u = 0; r = 0;
      k = int'($urandom_range(99));
      if (k < 1) r = 1;
      else if (k < 3) begin d = 1; u = 1; end
      else if (k < 5) u = 1;
      else if (!btn) begin
        if ($urandom_range(5) == 0) begin
          d = 1; btn = 1; hold = int'($urandom_range(1, 16));
        end
      end else if (hold == 0) begin
        u = 1; btn = 0;
      end else hold--;
      step(d, u, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
